// File: rtl/fft_pkg.sv
// Shared types and default sizing for the radix-2 FFT sequencer.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        UNLOAD
    } state_e;

    localparam int DEF_LOG2_N       = 11;
    localparam int DEF_BFLY_LATENCY = 4;
    localparam int DEF_STAGE_W      = 4;

endpackage

// File: rtl/fft_issue_delay.sv
// Delays the butterfly read strobe to its write-back slot; pending_o flags
// any write-back still in flight so the sequencer can drain between stages.
module fft_issue_delay #(
    parameter int LATENCY = 4
) (
    input  logic clock_i,
    input  logic clear_i,
    input  logic en_i,
    output logic wb_o,
    output logic pending_o
);

    logic [LATENCY-1:0] vld_pipe_q;

    generate
        if (LATENCY == 1) begin : g_one
            always_ff @(posedge clock_i) begin
                if (clear_i) vld_pipe_q <= '0;
                else         vld_pipe_q <= en_i;
            end
        end else begin : g_many
            always_ff @(posedge clock_i) begin
                if (clear_i) vld_pipe_q <= '0;
                else         vld_pipe_q <= {vld_pipe_q[LATENCY-2:0], en_i};
            end
        end
    endgenerate

    assign wb_o      = vld_pipe_q[LATENCY-1];
    assign pending_o = |vld_pipe_q;

endmodule

// File: rtl/fft_sequencer.sv
// Control FSM for the in-place radix-2 FFT: load N samples, run LOG2_N
// butterfly stages with a drain between stages, then stream results out.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2_N       = DEF_LOG2_N,
    parameter int BFLY_LATENCY = DEF_BFLY_LATENCY,
    parameter int STAGE_W      = DEF_STAGE_W
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               load_we_o,
    output logic [LOG2_N-1:0]  load_addr_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [LOG2_N-1:0]  unload_addr_o,
    output logic               addr_reset_o,
    output logic               addr_enable_o,
    output logic               bfly_wb_we_o,
    output logic [STAGE_W-1:0] stage_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int N  = 1 << LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam int PW = LOG2_N - 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      load_cnt_q, load_cnt_d;
    logic [CW-1:0]      out_cnt_q, out_cnt_d;
    logic [PW-1:0]      pair_cnt_q, pair_cnt_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               out_valid_q, out_valid_d;
    logic               done_q, done_d;
    logic               load_hs, out_hs, wb_pending;

    assign load_hs = in_valid_i & (state_q == LOAD);
    assign out_hs  = out_valid_q & out_ready_i;

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        out_cnt_d     = out_cnt_q;
        pair_cnt_d    = pair_cnt_q;
        stage_d       = stage_q;
        done_d        = 1'b0;
        in_ready_o    = 1'b0;
        addr_reset_o  = 1'b0;
        addr_enable_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_reset_o = 1'b1;
                    state_d      = LOAD;
                    load_cnt_d   = '0;
                    out_cnt_d    = '0;
                    pair_cnt_d   = '0;
                    stage_d      = '0;
                end
            end
            LOAD: begin
                in_ready_o = 1'b1;
                if (load_hs) begin
                    if (load_cnt_q == CW'(N - 1)) begin
                        load_cnt_d = '0;
                        state_d    = COMPUTE;
                    end else begin
                        load_cnt_d = load_cnt_q + CW'(1);
                    end
                end
            end
            COMPUTE: begin
                addr_enable_o = 1'b1;
                pair_cnt_d    = pair_cnt_q + PW'(1);
                if (pair_cnt_q == PW'(N / 2 - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                // The generator's index already encodes the stage, so no addr_reset here.
                if (!wb_pending) begin
                    if (stage_q == STAGE_W'(LOG2_N - 1)) begin
                        state_d = UNLOAD;
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                        state_d = COMPUTE;
                    end
                end
            end
            UNLOAD: begin
                if (out_hs) begin
                    if (out_cnt_q == CW'(N - 1)) begin
                        out_cnt_d = '0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Read data lags the address by one cycle, so valid trails UNLOAD entry.
        out_valid_d = (state_q == UNLOAD) && (state_d == UNLOAD);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            load_cnt_q  <= '0;
            out_cnt_q   <= '0;
            pair_cnt_q  <= '0;
            stage_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            out_cnt_q   <= out_cnt_d;
            pair_cnt_q  <= pair_cnt_d;
            stage_q     <= stage_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    fft_issue_delay #(
        .LATENCY (BFLY_LATENCY)
    ) u_issue_delay (
        .clock_i   (clock_i),
        .clear_i   (reset_i),
        .en_i      (addr_enable_o),
        .wb_o      (bfly_wb_we_o),
        .pending_o (wb_pending)
    );

    // Look ahead one address on a handshake so the stream runs at full rate.
    assign unload_addr_o = LOG2_N'(out_cnt_q + CW'(out_hs));
    assign load_addr_o   = load_cnt_q[LOG2_N-1:0];
    assign load_we_o     = in_valid_i & in_ready_o;
    assign out_valid_o   = out_valid_q;
    assign stage_o       = stage_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Randomized bench for fft_sequencer (N=8, butterfly latency 2) with a
// behavioural memory and an event-log reference model.
module tb_fft_sequencer;

    localparam int LOG2_N = 3;
    localparam int LAT    = 2;
    localparam int SW     = 4;
    localparam int N      = 8;
    localparam int PER    = N / 2 + LAT + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, load_we, out_valid, addr_reset, addr_enable;
    logic          bfly_wb_we, busy, done;
    logic [LOG2_N-1:0] load_addr, unload_addr;
    logic [SW-1:0] stage;

    always #5 clock = ~clock;

    fft_sequencer #(
        .LOG2_N       (LOG2_N),
        .BFLY_LATENCY (LAT),
        .STAGE_W      (SW)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .start_i       (start),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .load_we_o     (load_we),
        .load_addr_o   (load_addr),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .unload_addr_o (unload_addr),
        .addr_reset_o  (addr_reset),
        .addr_enable_o (addr_enable),
        .bfly_wb_we_o  (bfly_wb_we),
        .stage_o       (stage),
        .busy_o        (busy),
        .done_o        (done)
    );

    // Working memory stand-in: loads write, butterflies leave data untouched,
    // so the result stream must replay the loaded samples in order.
    logic [15:0] mem [N];
    logic [15:0] in_data = '0;
    logic [15:0] rdata_q = '0;
    always @(posedge clock) begin
        if (load_we) mem[load_addr] <= in_data;
        rdata_q <= mem[unload_addr];
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    int cyc = 0;
    int en_c[$], en_s[$], wb_c[$], ar_c[$], ld_a[$], hs_d[$], done_c[$];
    int first_ov, last_hs, last_ld, start_c, overlap, addr_err, done_busy, hs_n;
    int samp [N];

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (start && !busy) start_c = cyc;
            if (addr_enable) begin
                en_c.push_back(cyc);
                en_s.push_back(int'(stage));
            end
            if (bfly_wb_we) wb_c.push_back(cyc);
            if (addr_reset) ar_c.push_back(cyc);
            if (addr_reset && addr_enable) overlap++;
            if (load_we) begin
                ld_a.push_back(int'(load_addr));
                last_ld = cyc;
            end
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                if (int'(unload_addr) != ((hs_n + int'(out_ready)) % N)) addr_err++;
                if (out_ready) begin
                    hs_d.push_back(int'(rdata_q));
                    hs_n++;
                    last_hs = cyc;
                end
            end
            if (done) begin
                done_c.push_back(cyc);
                done_busy = int'(busy);
            end
        end
    end

    task automatic clear_logs();
        en_c.delete(); en_s.delete(); wb_c.delete(); ar_c.delete();
        ld_a.delete(); hs_d.delete(); done_c.delete();
        first_ov = -1; last_hs = -1; last_ld = -1; start_c = -1;
        overlap = 0; addr_err = 0; done_busy = 1; hs_n = 0;
    endtask

    task automatic check_run(input bit full_rate);
        chk("addr_reset_count", ar_c.size(), 1);
        if (ar_c.size() == 1) chk("addr_reset_cycle", ar_c[0], start_c);
        chk("load_count", ld_a.size(), N);
        for (int i = 0; i < ld_a.size() && i < N; i++) chk("load_addr", ld_a[i], i);
        chk("issue_count", en_c.size(), 3 * N / 2);
        chk("wb_count", wb_c.size(), 3 * N / 2);
        if (en_c.size() == 3 * N / 2) begin
            chk("first_issue", en_c[0], last_ld + 1);
            for (int i = 0; i < 3 * N / 2; i++) begin
                chk("issue_stage", en_s[i], i / (N / 2));
                chk("issue_cycle", en_c[i], en_c[0] + (i / (N / 2)) * PER + i % (N / 2));
            end
            if (wb_c.size() == 3 * N / 2) begin
                for (int i = 0; i < 3 * N / 2; i++) chk("wb_delay", wb_c[i] - en_c[i], LAT);
                chk("stage1_after_wb", int'(en_c[4] > wb_c[3]), 1);
                chk("stage2_after_wb", int'(en_c[8] > wb_c[7]), 1);
                chk("first_out_valid", first_ov, wb_c[11] + 3);
            end
        end
        chk("hs_count", hs_d.size(), N);
        for (int i = 0; i < hs_d.size() && i < N; i++) chk("out_data", hs_d[i], samp[i]);
        if (full_rate) chk("stream_span", last_hs - first_ov, N - 1);
        chk("done_count", done_c.size(), 1);
        if (done_c.size() == 1) chk("done_cycle", done_c[0], last_hs + 1);
        chk("done_busy", done_busy, 0);
        chk("reset_enable_overlap", overlap, 0);
        chk("unload_addr_track", addr_err, 0);
    endtask

    // vmode: 0 = in_valid always high, 1 = random; rmode: 0 = ready high,
    // 1 = ready toggling 1,0,..., 2 = random.
    task automatic run_transform(input int vmode, input int rmode, input bit pokes);
        int idx, guard;
        bit hs, got_done;
        clear_logs();
        for (int i = 0; i < N; i++) samp[i] = int'($urandom_range(0, 65535));
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        idx = 0; guard = 0;
        while (idx < N && guard < 200) begin
            in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            in_data  = 16'(samp[idx]);
            start    = pokes && ($urandom_range(0, 3) == 0);
            #1;
            hs = in_valid && in_ready;
            @(posedge clock); #1;
            if (hs) idx++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("load_finished", idx, N);
        guard = 0; got_done = 1'b0;
        while (!got_done && guard < 500) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (guard % 2 == 0);
                default: out_ready = 1'(($urandom_range(0, 1)));
            endcase
            start = pokes && busy && ($urandom_range(0, 5) == 0);
            #1;
            if (done) got_done = 1'b1;
            @(posedge clock); #1;
            guard++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        chk("done_seen", int'(got_done), 1);
        check_run(rmode == 0);
    endtask

    task automatic reset_mid_compute();
        int g, wbn;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        in_valid = 1'b1;
        repeat (N) begin
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        g = 0;
        while (!addr_enable && g < 20) begin
            @(posedge clock); #1;
            g++;
        end
        chk("reached_compute", int'(addr_enable), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_stage", int'(stage), 0);
        wbn = 0;
        repeat (4) begin
            if (bfly_wb_we) wbn++;
            @(posedge clock); #1;
        end
        chk("rst_no_wb", wbn, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_strobes", int'({addr_reset, addr_enable, bfly_wb_we, load_we}), 0);
        chk("reset_stage", int'(stage), 0);
        chk("reset_load_addr", int'(load_addr), 0);
        chk("reset_unload_addr", int'(unload_addr), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_transform(0, 0, 1'b0);
        run_transform(0, 1, 1'b0);
        run_transform(1, 2, 1'b1);
        reset_mid_compute();
        run_transform(1, 2, 1'b0);
        run_transform(0, 0, 1'b1);
        run_transform(1, 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
